// File: rtl/wait_reqgen.sv
// Z80 IO wait request generator: gluclock/comport start pulse 1 cycle after iorq_s, wait_end after spi_done; busy drops new iorq_s.
// Optional HOLD timeout under `WAIT_TIMEOUT_EN (forced wait_end, sticky timed_out); without it HOLD waits for spi_done forever.
module wait_reqgen #(
   parameter logic [15:0] GLU_PORT = 16'hBFF7,
   parameter logic [7:0]  COM_PORT = 8'hEF,
   parameter logic [11:0] TIMEOUT  = 12'd4095
) (
   input  logic        fclk,
   input  logic        rst,
   input  logic        iorq_s,
   input  logic [15:0] a,
   input  logic        rnw,
   input  logic [7:0]  din,
   input  logic        gluclock_ena,
   input  logic        spi_done,
   output logic        wait_start_gluclock,
   output logic        wait_start_comport,
   output logic        wait_end,
   output logic [7:0]  wait_addr,
   output logic [7:0]  wait_wrdata,
   output logic        wait_rnw,
   output logic        busy,
   output logic        timed_out
);

   typedef enum logic [1:0] {IDLE, START, HOLD, END} state_t;

   state_t state;
   logic   pending;
   logic   glu_match;
   logic   com_match;

   // Gluclock wins when both decode, so comport only sees the leftover.
   assign glu_match = iorq_s & gluclock_ena & (a == GLU_PORT);
   assign com_match = iorq_s & (a[7:0] == COM_PORT) & ~glu_match;

`ifdef WAIT_TIMEOUT_EN
   logic [11:0] hold_cnt;
   logic        timed_out_q;

   assign timed_out = timed_out_q;
`else
   assign timed_out = 1'b0;
`endif

   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         state               <= IDLE;
         pending             <= 1'b0;
         wait_start_gluclock <= 1'b0;
         wait_start_comport  <= 1'b0;
         wait_end            <= 1'b0;
         busy                <= 1'b0;
         wait_addr           <= 8'h00;
         wait_wrdata         <= 8'h00;
         wait_rnw            <= 1'b1;
`ifdef WAIT_TIMEOUT_EN
         hold_cnt            <= 12'd0;
         timed_out_q         <= 1'b0;
`endif
      end else begin
         wait_start_gluclock <= 1'b0;
         wait_start_comport  <= 1'b0;
         wait_end            <= 1'b0;
         case (state)
            IDLE: begin
               if (glu_match | com_match) begin
                  state               <= START;
                  busy                <= 1'b1;
                  pending             <= 1'b0;
                  wait_addr           <= a[7:0];
                  wait_wrdata         <= din;
                  wait_rnw            <= rnw;
                  // The start pulse registers double as the latched source.
                  wait_start_gluclock <= glu_match;
                  wait_start_comport  <= com_match;
`ifdef WAIT_TIMEOUT_EN
                  timed_out_q         <= 1'b0;
`endif
               end
            end
            START: begin
               state <= HOLD;
               if (spi_done)
                  pending <= 1'b1;
`ifdef WAIT_TIMEOUT_EN
               hold_cnt <= 12'd0;
`endif
            end
            HOLD: begin
               if (spi_done | pending) begin
                  state    <= END;
                  wait_end <= 1'b1;
                  pending  <= 1'b0;
               end
`ifdef WAIT_TIMEOUT_EN
               // hold_cnt+1 is the number of HOLD cycles including this one.
               else if (hold_cnt + 12'd1 == TIMEOUT) begin
                  state       <= END;
                  wait_end    <= 1'b1;
                  timed_out_q <= 1'b1;
               end else begin
                  hold_cnt <= hold_cnt + 12'd1;
               end
`endif
            end
            END: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_wait_reqgen.sv
// Directed self-checking bench for wait_reqgen (DUT built with TIMEOUT=20).
module tb_wait_reqgen;

   logic        fclk = 1'b0;
   logic        rst;
   logic        iorq_s;
   logic [15:0] a;
   logic        rnw;
   logic [7:0]  din;
   logic        gluclock_ena;
   logic        spi_done;
   logic        wait_start_gluclock;
   logic        wait_start_comport;
   logic        wait_end;
   logic [7:0]  wait_addr;
   logic [7:0]  wait_wrdata;
   logic        wait_rnw;
   logic        busy;
   logic        timed_out;

   int errors = 0;
   int checks = 0;

   wait_reqgen #(
      .GLU_PORT(16'hBFF7),
      .COM_PORT(8'hEF),
      .TIMEOUT (12'd20)
   ) dut (
      .fclk               (fclk),
      .rst                (rst),
      .iorq_s             (iorq_s),
      .a                  (a),
      .rnw                (rnw),
      .din                (din),
      .gluclock_ena       (gluclock_ena),
      .spi_done           (spi_done),
      .wait_start_gluclock(wait_start_gluclock),
      .wait_start_comport (wait_start_comport),
      .wait_end           (wait_end),
      .wait_addr          (wait_addr),
      .wait_wrdata        (wait_wrdata),
      .wait_rnw           (wait_rnw),
      .busy               (busy),
      .timed_out          (timed_out)
   );

   always #5 fclk = ~fclk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge fclk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; iorq_s = 1'b0; a = 16'h0000; rnw = 1'b1; din = 8'h00;
      gluclock_ena = 1'b0; spi_done = 1'b0;
      tick(); tick();
      checks++; if ({wait_start_gluclock, wait_start_comport, wait_end, busy, timed_out} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {wait_start_gluclock, wait_start_comport, wait_end, busy, timed_out}); end
      checks++; if ({wait_addr, wait_wrdata, wait_rnw} !== {8'h00, 8'h00, 1'b1}) begin
         errors++; $display("FAIL reset_fields: got %h/%h/%b want 00/00/1", wait_addr, wait_wrdata, wait_rnw); end
      rst = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
   endtask

   task automatic test_glu_write();
      gluclock_ena = 1'b1; a = 16'hBFF7; rnw = 1'b0; din = 8'h5A; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0; a = 16'h0000; din = 8'h00; rnw = 1'b1;
      checks++; if ({wait_start_gluclock, wait_start_comport, busy} !== 3'b101) begin
         errors++; $display("FAIL glu_start: glu/com/busy got %b want 101", {wait_start_gluclock, wait_start_comport, busy}); end
      checks++; if ({wait_addr, wait_wrdata, wait_rnw} !== {8'hF7, 8'h5A, 1'b0}) begin
         errors++; $display("FAIL glu_fields: got %h/%h/%b want F7/5A/0", wait_addr, wait_wrdata, wait_rnw); end
      tick();
      checks++; if ({wait_start_gluclock, wait_end, busy} !== 3'b001) begin
         errors++; $display("FAIL glu_pulse_width: glu/end/busy got %b want 001", {wait_start_gluclock, wait_end, busy}); end
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      checks++; if ({wait_end, busy} !== 2'b11) begin
         errors++; $display("FAIL glu_end: end/busy got %b want 11", {wait_end, busy}); end
      tick();
      checks++; if ({wait_end, busy} !== 2'b00) begin
         errors++; $display("FAIL glu_idle: end/busy got %b want 00", {wait_end, busy}); end
      checks++; if ({wait_addr, wait_wrdata, wait_rnw} !== {8'hF7, 8'h5A, 1'b0}) begin
         errors++; $display("FAIL glu_fields_hold: got %h/%h/%b want F7/5A/0", wait_addr, wait_wrdata, wait_rnw); end
   endtask

   task automatic test_comport_read();
      int seen_end;
      gluclock_ena = 1'b1; a = 16'h12EF; rnw = 1'b1; din = 8'hC3; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0; a = 16'h0000;
      checks++; if ({wait_start_gluclock, wait_start_comport, busy} !== 3'b011) begin
         errors++; $display("FAIL com_start: glu/com/busy got %b want 011", {wait_start_gluclock, wait_start_comport, busy}); end
      checks++; if ({wait_addr, wait_wrdata, wait_rnw} !== {8'hEF, 8'hC3, 1'b1}) begin
         errors++; $display("FAIL com_fields: got %h/%h/%b want EF/C3/1", wait_addr, wait_wrdata, wait_rnw); end
      seen_end = 0;
      for (int i = 0; i < 9; i++) begin
         tick();
         if (wait_end === 1'b1 || busy !== 1'b1) seen_end++;
      end
      checks++; if (seen_end !== 0) begin
         errors++; $display("FAIL com_hold: early end/idle cycles got %0d want 0", seen_end); end
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      checks++; if (wait_end !== 1'b1) begin errors++; $display("FAIL com_end: got %b want 1", wait_end); end
      tick();
      checks++; if ({wait_end, busy} !== 2'b00) begin
         errors++; $display("FAIL com_idle: end/busy got %b want 00", {wait_end, busy}); end
   endtask

   task automatic test_glu_disabled();
      gluclock_ena = 1'b0; a = 16'hBFF7; rnw = 1'b0; din = 8'h11; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0;
      checks++; if ({wait_start_gluclock, wait_start_comport, busy} !== 3'b000) begin
         errors++; $display("FAIL glu_disabled: glu/com/busy got %b want 000", {wait_start_gluclock, wait_start_comport, busy}); end
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL glu_disabled_busy: got %b want 0", busy); end
      a = 16'h00EF; din = 8'h22; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0;
      checks++; if ({wait_start_gluclock, wait_start_comport, wait_addr} !== {2'b01, 8'hEF}) begin
         errors++; $display("FAIL com_lowbyte: glu/com/addr got %b/%h want 01/EF", {wait_start_gluclock, wait_start_comport}, wait_addr); end
      tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL com_lowbyte_done: busy got %b want 0", busy); end
   endtask

   task automatic test_back_to_back();
      int early;
      gluclock_ena = 1'b1; a = 16'hBFF7; rnw = 1'b1; din = 8'h33; iorq_s = 1'b1;
      tick();
      // START cycle: spi_done early, plus a competing request that must be dropped
      spi_done = 1'b1; a = 16'h00EF; din = 8'h99; rnw = 1'b0; iorq_s = 1'b1;
      tick();
      spi_done = 1'b0; iorq_s = 1'b0;
      checks++; if ({wait_start_comport, wait_end, busy} !== 3'b001) begin
         errors++; $display("FAIL pend_hold: com/end/busy got %b want 001", {wait_start_comport, wait_end, busy}); end
      tick();
      checks++; if (wait_end !== 1'b1) begin errors++; $display("FAIL pend_end: got %b want 1", wait_end); end
      checks++; if ({wait_addr, wait_wrdata, wait_rnw} !== {8'hF7, 8'h33, 1'b1}) begin
         errors++; $display("FAIL busy_ignore: got %h/%h/%b want F7/33/1", wait_addr, wait_wrdata, wait_rnw); end
      // spi_done during END and then in IDLE must leave nothing pending
      spi_done = 1'b1;
      tick();
      tick();
      spi_done = 1'b0;
      a = 16'hBFF7; din = 8'h44; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0;
      early = 0;
      for (int i = 0; i < 4; i++) begin
         tick();
         if (wait_end === 1'b1) early++;
      end
      checks++; if ({early[3:0], busy} !== {4'd0, 1'b1}) begin
         errors++; $display("FAIL stale_spi_done: early ends %0d busy %b want 0/1", early, busy); end
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick();
      checks++; if (busy !== 1'b0) begin errors++; $display("FAIL stale_done_idle: busy got %b want 0", busy); end
   endtask

   task automatic test_timeout();
      int n;
      gluclock_ena = 1'b1; a = 16'hBFF7; rnw = 1'b0; din = 8'h01; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0;
`ifdef WAIT_TIMEOUT_EN
      n = 0;
      while (wait_end !== 1'b1 && n < 100) begin
         tick();
         n++;
      end
      // 20 HOLD cycles, then END appears on the 21st edge after START
      checks++; if (n !== 21) begin errors++; $display("FAIL timeout_len: edges to end got %0d want 21", n); end
      checks++; if (timed_out !== 1'b1) begin errors++; $display("FAIL timeout_flag: got %b want 1", timed_out); end
      tick(); tick();
      checks++; if ({timed_out, busy} !== 2'b10) begin
         errors++; $display("FAIL timeout_sticky: flag/busy got %b want 10", {timed_out, busy}); end
      iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0;
      checks++; if (timed_out !== 1'b0) begin errors++; $display("FAIL timeout_clear: got %b want 0", timed_out); end
      tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      tick();
      checks++; if ({timed_out, busy} !== 2'b00) begin
         errors++; $display("FAIL timeout_normal: flag/busy got %b want 00", {timed_out, busy}); end
`else
      n = 0;
      for (int i = 0; i < 30; i++) begin
         tick();
         if (wait_end === 1'b1 || timed_out === 1'b1) n++;
      end
      checks++; if ({n[3:0], busy} !== {4'd0, 1'b1}) begin
         errors++; $display("FAIL no_timeout: ends %0d busy %b want 0/1", n, busy); end
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      checks++; if ({wait_end, timed_out} !== 2'b10) begin
         errors++; $display("FAIL no_timeout_end: end/flag got %b want 10", {wait_end, timed_out}); end
      tick();
`endif
   endtask

   task automatic test_reset_mid();
      int ends;
      gluclock_ena = 1'b1; a = 16'h34EF; rnw = 1'b0; din = 8'h77; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0;
      tick(); tick();
      rst = 1'b1;
      #1;
      checks++; if ({wait_start_comport, wait_end, busy, timed_out} !== 4'b0) begin
         errors++; $display("FAIL rst_mid_flags: got %b want 0000", {wait_start_comport, wait_end, busy, timed_out}); end
      checks++; if ({wait_addr, wait_wrdata, wait_rnw} !== {8'h00, 8'h00, 1'b1}) begin
         errors++; $display("FAIL rst_mid_fields: got %h/%h/%b want 00/00/1", wait_addr, wait_wrdata, wait_rnw); end
      spi_done = 1'b1;
      tick();
      rst = 1'b0;
      ends = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (wait_end === 1'b1 || busy === 1'b1) ends++;
      end
      spi_done = 1'b0;
      checks++; if (ends !== 0) begin errors++; $display("FAIL rst_no_end: end/busy cycles got %0d want 0", ends); end
      a = 16'hBFF7; din = 8'hA5; rnw = 1'b1; iorq_s = 1'b1;
      tick();
      iorq_s = 1'b0;
      checks++; if ({wait_start_gluclock, wait_addr, wait_wrdata} !== {1'b1, 8'hF7, 8'hA5}) begin
         errors++; $display("FAIL rst_new_req: glu/addr/data got %b/%h/%h want 1/F7/A5", wait_start_gluclock, wait_addr, wait_wrdata); end
      tick();
      spi_done = 1'b1;
      tick();
      spi_done = 1'b0;
      checks++; if (wait_end !== 1'b1) begin errors++; $display("FAIL rst_new_end: got %b want 1", wait_end); end
      tick();
   endtask

   initial begin
      test_reset();
      test_glu_write();
      test_comport_read();
      test_glu_disabled();
      test_back_to_back();
      test_timeout();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
